// File: rtl/jtvigil_rom_pkg.sv
// Shared types and helpers for the two-slot ROM arbiter on one SDRAM bank.
package jtvigil_rom_pkg;

   localparam int unsigned SDRAM_DW = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      WAIT_DATA
   } arb_st_e;

   // Slot address (in slot-width units) to 16-bit SDRAM word address
   function automatic logic [31:0] word_addr(input logic [31:0] addr, input int unsigned dw);
      logic [31:0] w;
      w = addr;
      if (dw == 8) begin
         w = addr >> 1;
      end else if (dw == 32) begin
         w = addr << 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/jtvigil_rom_cache.sv
// One-entry address/data cache for a single ROM slot: tag, valid, data, hit and lane mux.
module jtvigil_rom_cache
   import jtvigil_rom_pkg::*;
#(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cs_i,
   input  logic [AW-1:0]               addr_i,
   input  logic                        grant_i,
   input  logic [((DW == 32) ? 2 : 1)-1:0] lane_we_i,
   input  logic [SDRAM_DW-1:0]         wdata_i,
   input  logic                        fill_i,
   output logic [DW-1:0]               dout_o,
   output logic                        ok_o,
   output logic                        miss_o
);

   localparam int unsigned NL = (DW == 32) ? 2 : 1;
   localparam int unsigned CW = NL * SDRAM_DW;
   // Byte slots share one cached word, so the byte-select bit is not part of the tag
   localparam int unsigned TW = (DW == 8) ? AW - 1 : AW;

   logic [TW-1:0] tag_q;
   logic          valid_q;
   logic [CW-1:0] data_q;
   logic          tag_match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q   <= '0;
         valid_q <= 1'b0;
      end else if (grant_i) begin
         tag_q   <= addr_i[AW-1 -: TW];
         valid_q <= 1'b0;
      end else if (fill_i) begin
         valid_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         for (int i = 0; i < int'(NL); i++) begin
            if (lane_we_i[i]) data_q[i*SDRAM_DW +: SDRAM_DW] <= wdata_i;
         end
      end
   end

   assign tag_match = (tag_q == addr_i[AW-1 -: TW]);
   assign ok_o      = cs_i & valid_q & tag_match;
   assign miss_o    = cs_i & ~(valid_q & tag_match);

   generate
      if (DW == 8) begin : g_byte
         assign dout_o = addr_i[0] ? data_q[15:8] : data_q[7:0];
      end else begin : g_word
         assign dout_o = data_q;
      end
   endgenerate

endmodule

// File: rtl/jtvigil_rom_arb.sv
// Two ROM slots sharing one SDRAM bank read port; misses are fetched round-robin.
module jtvigil_rom_arb
   import jtvigil_rom_pkg::*;
#(
   parameter int unsigned        SLOT0_DW     = 8,
   parameter int unsigned        SLOT0_AW     = 16,
   parameter int unsigned        SLOT1_DW     = 8,
   parameter int unsigned        SLOT1_AW     = 16,
   parameter int unsigned        SDRAM_AW     = 22,
   parameter logic [SDRAM_AW-1:0] SLOT1_OFFSET = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                slot0_cs_i,
   input  logic [SLOT0_AW-1:0] slot0_addr_i,
   output logic [SLOT0_DW-1:0] slot0_dout_o,
   output logic                slot0_ok_o,
   input  logic                slot1_cs_i,
   input  logic [SLOT1_AW-1:0] slot1_addr_i,
   output logic [SLOT1_DW-1:0] slot1_dout_o,
   output logic                slot1_ok_o,
   output logic [SDRAM_AW-1:0] sdram_addr_o,
   output logic                sdram_req_o,
   input  logic                sdram_ack_i,
   input  logic                data_dst_i,
   input  logic                data_rdy_i,
   input  logic [SDRAM_DW-1:0] data_read_i
);

   localparam int unsigned NL0 = (SLOT0_DW == 32) ? 2 : 1;
   localparam int unsigned NL1 = (SLOT1_DW == 32) ? 2 : 1;

   arb_st_e             st_q, st_d;
   logic                req_q, req_d;
   logic [SDRAM_AW-1:0] addr_q, addr_d;
   logic                gnt_q, gnt_d;
   logic                ptr_q, ptr_d;
   logic                cnt_q, cnt_d;

   logic                miss0, miss1;
   logic                pick1;
   logic                wide_gnt;
   logic                grant0, grant1;
   logic                we0, we1;
   logic                fill0, fill1;
   logic [NL0-1:0]      lane_we0;
   logic [NL1-1:0]      lane_we1;
   logic [SDRAM_AW-1:0] waddr0, waddr1;

   assign waddr0 = SDRAM_AW'(word_addr(32'(slot0_addr_i), SLOT0_DW));
   assign waddr1 = SDRAM_AW'(word_addr(32'(slot1_addr_i), SLOT1_DW)) + SLOT1_OFFSET;

   // On a double miss, serve the slot that did not get the last grant
   assign pick1    = miss1 & (~miss0 | ~ptr_q);
   assign wide_gnt = gnt_q ? (SLOT1_DW == 32) : (SLOT0_DW == 32);
   assign lane_we0 = {NL0{we0}} & (NL0'(1) << cnt_q);
   assign lane_we1 = {NL1{we1}} & (NL1'(1) << cnt_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= IDLE;
         req_q  <= 1'b0;
         addr_q <= '0;
         gnt_q  <= 1'b0;
         ptr_q  <= 1'b0;
         cnt_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         req_q  <= req_d;
         addr_q <= addr_d;
         gnt_q  <= gnt_d;
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      req_d  = req_q;
      addr_d = addr_q;
      gnt_d  = gnt_q;
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      grant0 = 1'b0;
      grant1 = 1'b0;
      we0    = 1'b0;
      we1    = 1'b0;
      fill0  = 1'b0;
      fill1  = 1'b0;
      unique case (st_q)
         IDLE: begin
            if (miss0 | miss1) begin
               gnt_d  = pick1;
               addr_d = pick1 ? waddr1 : waddr0;
               req_d  = 1'b1;
               cnt_d  = 1'b0;
               grant0 = ~pick1;
               grant1 = pick1;
               st_d   = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (sdram_ack_i) begin
               req_d = 1'b0;
               st_d  = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (data_dst_i) begin
               we0 = ~gnt_q;
               we1 = gnt_q;
               if (wide_gnt) cnt_d = ~cnt_q;
            end
            if (data_rdy_i) begin
               fill0 = ~gnt_q;
               fill1 = gnt_q;
               ptr_d = gnt_q;
               st_d  = IDLE;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   assign sdram_req_o  = req_q;
   assign sdram_addr_o = addr_q;

   jtvigil_rom_cache #(
      .DW (SLOT0_DW),
      .AW (SLOT0_AW)
   ) u_cache0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs_i      (slot0_cs_i),
      .addr_i    (slot0_addr_i),
      .grant_i   (grant0),
      .lane_we_i (lane_we0),
      .wdata_i   (data_read_i),
      .fill_i    (fill0),
      .dout_o    (slot0_dout_o),
      .ok_o      (slot0_ok_o),
      .miss_o    (miss0)
   );

   jtvigil_rom_cache #(
      .DW (SLOT1_DW),
      .AW (SLOT1_AW)
   ) u_cache1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs_i      (slot1_cs_i),
      .addr_i    (slot1_addr_i),
      .grant_i   (grant1),
      .lane_we_i (lane_we1),
      .wdata_i   (data_read_i),
      .fill_i    (fill1),
      .dout_o    (slot1_dout_o),
      .ok_o      (slot1_ok_o),
      .miss_o    (miss1)
   );

endmodule

// File: doc/jtvigil_rom_arb.md
Name: jtvigil_rom_arb

Overview:
- Shares one SDRAM bank read port between two ROM slots, e.g. sound CPU plus ADPCM, or scroll 1 plus scroll 2.
- Each slot has a one-entry address/data cache.
- Slot misses become SDRAM read requests, granted round-robin.
- The block sits between the game's ROM consumers and the SDRAM controller's per-bank req/ack/dst/rdy interface.

Parameters:
SLOT0_DW, 8, slot 0 data width; legal values are 8, 16 and 32.
SLOT0_AW, 16, slot 0 address width, counted in slot-width units.
SLOT1_DW, 8, slot 1 data width; legal values are 8, 16 and 32.
SLOT1_AW, 16, slot 1 address width, counted in slot-width units.
SLOT1_OFFSET, 22'd0, SDRAM word offset added to slot 1 addresses.
SDRAM_AW, 22, SDRAM word address width.

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
slot0_cs  in  1  slot 0 read request, level
slot0_addr  in  SLOT0_AW  slot 0 address
slot0_dout  out  SLOT0_DW  slot 0 data
slot0_ok  out  1  slot 0 data valid for current address
slot1_cs  in  1  slot 1 read request, level
slot1_addr  in  SLOT1_AW  slot 1 address
slot1_dout  out  SLOT1_DW  slot 1 data
slot1_ok  out  1  slot 1 data valid for current address
sdram_addr  out  SDRAM_AW  word address of pending read
sdram_req  out  1  read request, held until ack
sdram_ack  in  1  controller accepted request, one-cycle pulse
data_dst  in  1  data_read carries a word for this bank
data_rdy  in  1  last word of the burst; coincides with a data_dst cycle
data_read  in  16  SDRAM read data

Behaviour:
- Reset (rst_n low, async) clears all state:
  - sdram_req=0, sdram_addr=0.
  - Both cache valid bits=0; both dout=0; both ok=0.
  - State=IDLE; round-robin pointer=0.
- Reset asserted mid-burst drops sdram_req immediately. Later dst/rdy pulses are ignored until a new request is acked.
- Address mapping per slot:
  - DW=8: word = addr>>1; byte lane = addr[0], 0 selects data_read[7:0].
  - DW=16: word = addr.
  - DW=32: word = addr<<1; two words per fetch, first word → dout[15:0], second → dout[31:16].
  - Slot 1 adds SLOT1_OFFSET, truncated to SDRAM_AW.
- Cache entry per slot:
  - Tag = full slot address; data = SDRAM data, full word(s).
  - DW=8 caches the 16-bit word; the tag ignores addr[0], so both bytes of a word hit.
- Hit check: slotN_ok = slotN_cs & validN & (tagN == slotN_addr). It is combinational on cs/addr, so an address change drops ok in the same cycle. slotN_dout is driven from the cache with the lane select.
- Miss: cs=1 and not hit.
- FSM:
  - IDLE: if either slot misses, pick one. A single miss is picked directly. If both miss, take the slot opposite the pointer's last grant.
    - Latch slot id, tag and sdram_addr; set sdram_req=1; clear that slot's valid bit.
    - Go to WAIT_ACK. This is one cycle from miss to req.
  - WAIT_ACK: on sdram_ack, sdram_req=0, go to WAIT_DATA. The request is never withdrawn, even if cs drops or the address changes.
  - WAIT_DATA: each data_dst cycle stores data_read into the next 16-bit lane of the granted entry (word counter 0..1).
    - On data_rdy, set valid, flip the pointer to the granted slot, go to IDLE.
    - ok can rise the cycle after rdy.
- The latched tag is the address at grant time. If the slot address changed during the fetch, the result is a miss and triggers a new fetch from IDLE.
- data_dst outside WAIT_DATA is ignored.
- A second data_dst without rdy on DW≤16 overwrites lane 0.
- No timeout. A controller that never acks stalls the bank; this is by design.
- Hits on the non-granted slot are served during any state.

Decomposition:
- Shared package jtvigil_rom_pkg:
  - FSM state enum (IDLE, WAIT_ACK, WAIT_DATA).
  - Function word_addr(addr, dw).
  - Constant SDRAM_DW=16.
- One natural sub-module, jtvigil_rom_cache: one slot's tag/valid/data entry, hit compare and lane mux. It is instantiated twice; the arbiter FSM stays in the top.

Test Plan:
1. Reset: rst_n low mid-WAIT_DATA, release → sdram_req=0, slot0_ok=slot1_ok=0; a rdy pulse 2 cycles later leaves valid=0.
2. 8-bit miss then hit: slot0_cs=1, addr=16'h0003 → next cycle sdram_req=1, sdram_addr=22'h1. Ack after 3 cycles, dst+rdy with data_read=16'hA55A → dout=8'hA5, ok=1 next cycle. Then addr=16'h0002 → ok=1 the same cycle, dout=8'h5A, no new req.
3. Offset + 32-bit: SLOT1_DW=32, SLOT1_OFFSET=22'h8000, addr=18'h00010 → sdram_addr=22'h8020. dst words 16'h1234 then 16'h5678 with rdy → dout=32'h5678_1234.
4. Simultaneous misses: both cs rise with pointer=0 → slot1 granted first; after its rdy, slot0 req within 1 cycle. Repeat → order alternates.
5. Address change during fetch: slot0 addr 0x10 granted, changes to 0x20 before rdy → ok stays 0, a second req goes out with sdram_addr for 0x20.
6. Hit during other slot's fetch: slot1 cached at 0x5, slot0 fetch in WAIT_DATA, slot1_addr=0x5 → slot1_ok=1 immediately.
